// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data and downstream valid/ready/data.
// The stage takes the slave view; the environment driving it takes the master view.
interface pipe_skid_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage with global hold, flush, and a saturating back-pressure counter.
// in_ready depends only on registered state and hold, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
    parameter int unsigned        WIDTH     = 32,
    parameter logic [WIDTH-1:0]   NOP_VALUE = WIDTH'(32'h0000_0013),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_skid_stage_if.slave      bus,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign bus.in_ready  = (state != TWO) & ~hold;
    assign bus.out_valid = (state != EMPTY) & ~hold;
    // main is left untouched by flush, so EMPTY must mask it explicitly
    assign bus.out_data  = (state != EMPTY) ? main_q : NOP_VALUE;
    assign occupancy     = state;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= NOP_VALUE;
            skid_q    <= NOP_VALUE;
            stall_cnt <= '0;
        end else begin
            // out_valid is already low under hold, so the counter freezes there too
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                state <= EMPTY;
            end else if (!hold) begin
                unique case (state)
                    EMPTY: begin
                        if (push) begin
                            main_q <= bus.in_data;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_q <= bus.in_data;
                        end else if (push) begin
                            skid_q <= bus.in_data;
                            state  <= TWO;
                        end else if (pop) begin
                            state  <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage (CNT_W = 4 to reach saturation quickly).
module tb_pipe_skid_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic             flush;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       occupancy;

    int checks   = 0;
    int failures = 0;

    pipe_skid_stage_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_stage #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .hold      (hold),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [5];

    initial begin
        stream[0] = 32'hA1; stream[1] = 32'hA2; stream[2] = 32'hA3;
        stream[3] = 32'hA4; stream[4] = 32'hA5;

        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        // reset values before any clock edge
        #2;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data, NOP);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        #10;
        rst_n = 1'b1;

        // stream: one-cycle latency, occupancy stays at 1
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stream[i];
            tick();
            chk("stream_data", bus.out_data, stream[i]);
            chk("stream_occ",  32'(occupancy), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drain_occ",  32'(occupancy), 32'd0);
        chk("stream_drain_data", bus.out_data, NOP);
        chk("stream_stall",      32'(stall_cnt), 32'd0);

        // skid: fill both entries under back-pressure
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h11;
        tick();
        bus.in_data = 32'h22;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("skid_occ",      32'(occupancy), 32'd2);
        chk("skid_in_ready", 32'(bus.in_ready), 32'd0);
        chk("skid_stall",    32'(stall_cnt), 32'd2);
        chk("skid_head0",    bus.out_data, 32'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("skid_head1", bus.out_data, 32'h22);
        chk("skid_occ1",  32'(occupancy), 32'd1);
        tick();
        chk("skid_occ0",  32'(occupancy), 32'd0);
        chk("skid_stall_kept", 32'(stall_cnt), 32'd2);

        // hold: freeze a full stage while both sides are active
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h55;
        tick();
        bus.in_data = 32'h66;
        tick();
        hold = 1'b1; bus.in_data = 32'h77; bus.out_ready = 1'b1;
        #1;
        chk("hold_in_ready",  32'(bus.in_ready), 32'd0);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
        tick(); tick(); tick();
        chk("hold_occ",   32'(occupancy), 32'd2);
        chk("hold_stall", 32'(stall_cnt), 32'd1);
        chk("hold_out_valid_end", 32'(bus.out_valid), 32'd0);
        hold = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("hold_head0", bus.out_data, 32'h55);
        tick();
        chk("hold_head1", bus.out_data, 32'h66);
        tick();
        chk("hold_occ0", 32'(occupancy), 32'd0);

        // flush: full stage with a simultaneous push that must be dropped
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h88;
        tick();
        bus.in_data = 32'h99;
        tick();
        flush = 1'b1; bus.in_data = 32'h33;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_occ",       32'(occupancy), 32'd0);
        chk("flush_out_data",  bus.out_data, NOP);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_stall",     32'(stall_cnt), 32'd3);
        bus.out_ready = 1'b1;
        tick();
        chk("flush_no_33", bus.out_data, NOP);
        chk("flush_occ2",  32'(occupancy), 32'd0);

        // saturation at 2^CNT_W-1
        bus.out_ready = 1'b0; cnt_clr = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'hAA;
        tick();
        cnt_clr = 1'b0; bus.in_valid = 1'b0;
        chk("sat_start", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_no_wrap", 32'(stall_cnt), 32'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr", 32'(stall_cnt), 32'd0);
        tick();
        chk("sat_after_clr", 32'(stall_cnt), 32'd1);

        // asynchronous reset mid-transfer
        bus.in_valid = 1'b1; bus.in_data = 32'hBB;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_occ",       32'(occupancy), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  bus.out_data, NOP);
        chk("arst_stall",     32'(stall_cnt), 32'd0);
        chk("arst_in_ready",  32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        #1;
        bus.in_valid = 1'b1; bus.in_data = 32'h44; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_data", bus.out_data, 32'h44);
        chk("post_rst_occ",  32'(occupancy), 32'd1);
        tick();
        chk("post_rst_drain", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
